// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, default line parameters and baud divisor shared by the UART transmitter and receiver
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 40000000;
    localparam int unsigned DEF_BAUD     = 9600;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with synchronous push/pop, registered full flag and occupancy count
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_nxt;

    // a push while full is dropped even when a pop frees a slot in the same cycle
    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge pclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count_nxt;
            full   <= (count_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push && !rst)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter with registered line and status outputs
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int          CW       = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    uart_state_t                  state;
    logic [CW-1:0]                baud_cnt;
    logic [2:0]                   bit_idx;
    logic [7:0]                   shift;
    logic [7:0]                   head;
    logic                         empty;
    logic                         load;
    logic [$clog2(FIFO_DEPTH):0]  count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk  (pclk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (load),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // a new frame starts from idle or straight out of a finished stop bit
    always_comb begin
        load = !empty && (state == IDLE || (state == STOP && baud_cnt == '0));
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_busy <= (state != IDLE) || (count != '0);
            if (load) begin
                state    <= START;
                tx       <= 1'b0;
                shift    <= head;
                baud_cnt <= RELOAD;
                tx_done  <= (state == STOP);
            end else if (state != IDLE && baud_cnt != '0) begin
                baud_cnt <= baud_cnt - CW'(1);
            end else begin
                case (state)
                    START: begin
                        state    <= DATA;
                        tx       <= shift[0];
                        shift    <= shift >> 1;
                        bit_idx  <= '0;
                        baud_cnt <= RELOAD;
                    end
                    DATA: begin
                        baud_cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    STOP: begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench; a line monitor decodes frames and compares them with queued expectations
module tb_uart_tx;

    localparam int BD = 10;

    logic       pclk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, tx, tx_busy, tx_done;
    logic       wr_en2;
    logic [7:0] wr_data2;
    logic       full2, tx2, tx_busy2, tx_done2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int sent = 0;
    int frames_done = 0;
    int last_wr = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int starts[$];

    uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .pclk(pclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx dut2 (
        .pclk(pclk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2),
        .full(full2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accept);
        @(posedge pclk); #1;
        wr_en = 1'b1;
        wr_data = d;
        last_wr = cyc;
        if (accept) begin
            exp_q.push_back(d);
            sent++;
        end
    endtask

    task automatic release_wr();
        @(posedge pclk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge pclk); #1;
        end
    endtask

    task automatic wait_starts(input int n, input int bound);
        int t = 0;
        while (starts.size() < n && t < bound) begin
            @(negedge pclk);
            t++;
        end
        check("frame_start_seen", 32'(starts.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (frames_done < sent && t < bound) begin
            @(negedge pclk);
            t++;
        end
        check("all_frames_done", 32'(frames_done), 32'(sent));
    endtask

    // current negedge sample is the first start-bit cycle; returns on the sample right after the stop bit
    task automatic check_frame();
        logic [7:0] exp_b;
        logic [7:0] got = '0;
        logic [9:0] line;
        int bad = 0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame at cycle %0d: got a start bit, required an idle line", cyc);
            exp_b = 8'h00;
        end else begin
            exp_b = exp_q.pop_front();
        end
        line = {1'b1, exp_b, 1'b0};
        starts.push_back(cyc);
        for (int s = 0; s < 10 * BD; s++) begin
            if (s != 0) @(negedge pclk);
            if (rst !== 1'b0) return;
            if (tx !== line[s / BD]) bad++;
            if (s != 0 && tx_done !== 1'b0) bad++;
            if (tx_busy !== 1'b1) bad++;
            if (s % BD == BD / 2 && s / BD >= 1 && s / BD <= 8) got[s / BD - 1] = tx;
        end
        @(negedge pclk);
        if (rst !== 1'b0) return;
        check("tx_done_at_frame_end", 32'(tx_done), 32'd1);
        check("frame_data", 32'(got), 32'(exp_b));
        check("frame_waveform_bad_samples", 32'(bad), 32'd0);
        frames_done++;
    endtask

    initial begin : monitor
        forever begin
            if (mon_en && rst === 1'b0 && tx === 1'b0) check_frame();
            else @(negedge pclk);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog at cycle %0d: got no end of test, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n0, sx, sa, t, t0, t1, t2, w;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        wr_en2 = 1'b0;
        wr_data2 = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        check("reset_tx_done", 32'(tx_done), 32'd0);
        check("reset_full", 32'(full), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        write_byte(8'hA5, 1'b1);
        w = last_wr;
        release_wr();
        wait_starts(1, 20);
        check("write_to_start_latency", 32'(starts[0] - w), 32'd2);
        wait_done(300);

        repeat (5) @(posedge pclk);
        n0 = starts.size();
        write_byte(8'h55, 1'b1);
        write_byte(8'h0F, 1'b1);
        write_byte(8'hFF, 1'b1);
        release_wr();
        wait_starts(n0 + 3, 400);
        check("gap_frame1_to_2", 32'(starts[n0 + 1] - starts[n0]), 32'd100);
        check("gap_frame2_to_3", 32'(starts[n0 + 2] - starts[n0 + 1]), 32'd100);
        wait_done(400);
        repeat (2) @(negedge pclk);
        check("busy_after_burst", 32'(tx_busy), 32'd0);

        n0 = starts.size();
        write_byte(8'h81, 1'b1);
        release_wr();
        wait_starts(n0 + 1, 20);
        sx = starts[n0];
        write_byte(8'hC1, 1'b1);
        write_byte(8'hC2, 1'b1);
        write_byte(8'hC3, 1'b1);
        write_byte(8'hC4, 1'b1);
        write_byte(8'hC5, 1'b0);
        @(negedge pclk);
        check("full_after_4_writes", 32'(full), 32'd1);
        release_wr();
        wait_cyc(sx + 99);
        check("full_before_pop", 32'(full), 32'd1);
        wr_en = 1'b1;
        wr_data = 8'hEE;
        @(posedge pclk); #1;
        wr_en = 1'b0;
        @(negedge pclk);
        check("full_after_pop_with_write", 32'(full), 32'd0);
        check("count_after_pop_with_write", 32'(dut.u_fifo.count), 32'd3);
        wait_done(800);

        repeat (5) @(posedge pclk);
        n0 = starts.size();
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        release_wr();
        wait_starts(n0 + 1, 20);
        sa = starts[n0];
        wait_cyc(sa + 54);
        rst = 1'b1;
        @(posedge pclk); #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_tx_busy", 32'(tx_busy), 32'd0);
        check("abort_full", 32'(full), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        sent = frames_done;
        repeat (300) @(negedge pclk);
        check("no_frames_after_abort", 32'(starts.size()), 32'(n0 + 1));
        write_byte(8'h3C, 1'b1);
        release_wr();
        wait_done(300);

        for (int i = 0; i < 24; i++) begin
            t = 0;
            while (exp_q.size() >= 4 && t < 2000) begin
                @(negedge pclk);
                t++;
            end
            if (t >= 2000) check("queue_drain_wait", 32'(exp_q.size()), 32'd3);
            repeat ($urandom_range(0, 120)) @(posedge pclk);
            write_byte(8'($urandom), 1'b1);
            check("full_low_with_room", 32'(full), 32'd0);
            release_wr();
        end
        wait_done(6000);
        repeat (2) @(negedge pclk);
        check("busy_after_random", 32'(tx_busy), 32'd0);

        @(posedge pclk); #1;
        wr_en2 = 1'b1;
        wr_data2 = 8'h00;
        @(posedge pclk); #1;
        wr_en2 = 1'b0;
        t = 0;
        while (tx2 !== 1'b0 && t < 20) begin
            @(negedge pclk);
            t++;
        end
        t0 = cyc;
        while (tx2 !== 1'b1 && cyc - t0 < 40000) @(negedge pclk);
        t1 = cyc;
        while (tx_done2 !== 1'b1 && cyc - t0 < 42000) @(negedge pclk);
        t2 = cyc;
        check("default_low_span_9_bits", 32'(t1 - t0), 32'd37503);
        check("default_frame_length", 32'(t2 - t0), 32'd41670);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
